// File: rtl/spi_master.sv
// spi_master: SPI master with a programmable sclk divider, runtime CPOL/CPHA
// selection and a parameterised bit order. The system clock drives all logic;
// sclk is a registered output.
// Optional feature: define SPI_MASTER_MISO_EN to build the miso receive path.
// Without it the miso port is ignored and dout is held at 0.
module spi_master #(
  parameter int unsigned DW        = 12,
  parameter int unsigned CLK_DIV   = 10,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          newd,
  input  logic [DW-1:0] din,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          miso,
  output logic          sclk,
  output logic          cs,
  output logic          mosi,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dout
);

  localparam int unsigned HW = $clog2(CLK_DIV);
  localparam int unsigned TW = $clog2(2 * DW + 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tog;
  logic [DW-1:0] tx_sr;
  logic          cpol_q;
  logic          cpha_q;

  logic          hdone;
  logic [TW-1:0] tog_next;

  // The bit that goes out next on mosi, and the register after it has left.
  function automatic logic tx_head(input logic [DW-1:0] v);
    return LSB_FIRST ? v[0] : v[DW-1];
  endfunction

  function automatic logic [DW-1:0] tx_shift(input logic [DW-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  // Half-period boundary and the number of the toggle about to happen.
  always_comb begin
    hdone    = (hcnt == HW'(CLK_DIV - 1));
    tog_next = tog + TW'(1);
  end

  // Transfer sequencer: owns every registered output except dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hcnt   <= '0;
      tog    <= '0;
      tx_sr  <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sclk   <= 1'b0;
      cs     <= 1'b1;
      mosi   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs   <= 1'b1;
          sclk <= cpol_q;
          mosi <= 1'b0;
          busy <= 1'b0;
          hcnt <= '0;
          tog  <= '0;
          if (newd) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            sclk   <= cpol;
            cs     <= 1'b0;
            busy   <= 1'b1;
            state  <= LEAD;
            // cpha=0 presents the first bit before the first sclk edge.
            if (!cpha) begin
              mosi  <= tx_head(din);
              tx_sr <= tx_shift(din);
            end else begin
              tx_sr <= din;
            end
          end
        end
        LEAD: begin
          if (hdone) begin
            hcnt  <= '0;
            state <= XFER;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        XFER: begin
          if (hdone) begin
            hcnt <= '0;
            sclk <= ~sclk;
            tog  <= tog_next;
            // Odd toggles launch data in cpha=1; even toggles do in cpha=0,
            // except the final one, which has no bit left to launch.
            if (tog_next[0] ? cpha_q
                            : (!cpha_q && tog_next != TW'(2 * DW))) begin
              mosi  <= tx_head(tx_sr);
              tx_sr <= tx_shift(tx_sr);
            end
            if (tog_next == TW'(2 * DW)) begin
              state <= TRAIL;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        TRAIL: begin
          if (hdone) begin
            hcnt  <= '0;
            tog   <= '0;
            cs    <= 1'b1;
            mosi  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_MISO_EN
  logic [DW-1:0] rx_sr;
  logic          sample_c;
  logic          fin_c;

  // miso is sampled on the edge opposite to the one that launches mosi.
  always_comb begin
    sample_c = (state == XFER) && hdone && (tog_next[0] ^ cpha_q);
    fin_c    = (state == TRAIL) && hdone;
  end

  // Receive shift register; the word is published on the done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr <= '0;
      dout  <= '0;
    end else begin
      if (sample_c) begin
        rx_sr <= LSB_FIRST ? {miso, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], miso};
      end
      if (fin_c) begin
        dout <= rx_sr;
      end
    end
  end
`else
  logic unused_miso;

  // No receive path in this build.
  assign unused_miso = miso;
  assign dout        = '0;
`endif

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI master: serialises a DW-bit word on mosi with a programmable sclk divider, runtime-selectable SPI mode (CPOL/CPHA) and bit order, and optionally captures miso into a parallel result. It replaces the fixed 12-bit, LSB-first, mode-0 transmitter in the SPI verification environment. It runs entirely in the system clock domain, with sclk as a registered output rather than an internal clock, and adds a busy/done handshake.

## Interface
- DW, 12: data word width in bits, ≥ 2.
- CLK_DIV, 10: clk cycles per sclk half-period, ≥ 2.
- LSB_FIRST, 1: 1 shifts bit 0 first; 0 shifts bit DW-1 first (both tx and rx).

- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- newd  input  1  start request, sampled only in IDLE.
- din  input  DW  transmit word, latched when newd is accepted.
- cpol  input  1  sclk idle level, latched with din.
- cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge. Latched with din.
- miso  input  1  serial receive data (used only with SPI_MASTER_MISO_EN).
- sclk  output  1  serial clock, registered.
- cs  output  1  chip select, active low, registered.
- mosi  output  1  serial transmit data, registered.
- busy  output  1  high from the accepting edge until the done cycle.
- done  output  1  one-cycle pulse at end of transfer.
- dout  output  DW  received word, valid from the done cycle until the next done.

## Operation
- States: IDLE → LEAD → XFER → TRAIL → IDLE. The done pulse is asserted on the TRAIL→IDLE edge.
- IDLE behaviour:
  - Outputs: cs=1, sclk=cpol_q, mosi=0, busy=0.
  - On newd=1: latch din, cpol and cpha into tx shift reg, cpol_q and cpha_q.
  - On that same edge: busy←1, cs←0, state←LEAD.
  - cpha_q=0: mosi←first bit on the accepting edge.
  - cpha_q=1: mosi stays 0 until the first sclk edge.
- LEAD: CLK_DIV cycles, with sclk held at cpol_q.
- XFER: 2·DW sclk toggles, one every CLK_DIV cycles. Toggles are numbered 1..2·DW; odd = leading edge, even = trailing edge.
- Edge actions (a shift and a sample are taken on the same clk edge that toggles sclk):
  - cpha_q=0: sample miso on odd toggles; shift mosi to the next bit on even toggles, except toggle 2·DW.
  - cpha_q=1: shift mosi to the next bit on odd toggles; sample miso on even toggles.
- TRAIL: CLK_DIV cycles, with sclk back at cpol_q and mosi holding the last bit.
- End of TRAIL (one edge): cs←1, mosi←0, done←1 for one cycle, busy←0, dout←rx shift reg, state←IDLE.
- newd while busy=1 is ignored (not queued). newd=1 in the done cycle is accepted; the next transfer starts back-to-back.
- Changes on din, cpol or cpha while busy have no effect on the current transfer.
- Bit order:
  - LSB_FIRST=1: tx shifts right; rx enters at bit DW-1 and shifts right.
  - LSB_FIRST=0: tx shifts left; rx enters at bit 0 and shifts left.
  - After DW samples, dout bit i equals the i-th transmitted bit position.
- Counters: the half-period counter counts 0..CLK_DIV-1 and wraps; the toggle counter is ceil(log2(2·DW+1)) bits wide.

## Timing
- Let edge N be the rising clk edge that samples newd=1.
- cs falls at edge N and rises at edge N+(2·DW+2)·CLK_DIV. done and busy=0 occur in the cycle following that edge.
- Toggle k occurs at edge N+(k+1)·CLK_DIV, for k=1..2·DW.
- Defaults (DW=12, CLK_DIV=10): cs low for 260 cycles; sclk period 20 cycles.
- Reset values, next clk edge with rst=1 (valid from any state, including mid-transfer):
  - Outputs: cs=1, sclk=0, mosi=0, busy=0, done=0, dout=0.
  - Internal: cpol_q=0, cpha_q=0, state=IDLE, all counters and shift regs 0.
- A partial transfer aborted by rst produces no done pulse.

## Configuration
- SPI_MASTER_MISO_EN defined: the rx shift reg and miso sampling are built, and dout updates on done.
- SPI_MASTER_MISO_EN undefined:
  - The miso port still exists but is ignored.
  - No rx register is built; dout is constant 0.
  - Transmit, sclk, cs and handshake timing are identical.

## Test plan
- Mode 0, defaults: din=12'hA5C, miso looped to mosi.
  - mosi bits sampled on sclk rising edges read 0,0,1,1,1,0,1,0,0,1,0,1.
  - cs is low for 260 cycles; done pulses once; dout=12'hA5C (MISO_EN).
- Mode 3 (cpol=1, cpha=1) with LSB_FIRST=0, DW=8, CLK_DIV=2, din=8'h81, miso tied 1.
  - sclk idles high; mosi reads 1,0,0,0,0,0,0,1 on sclk rising edges.
  - dout=8'hFF.
- newd held high through the whole transfer: exactly one transfer per done.
  - The second transfer's cs falls at the done edge; there is no extra transfer while busy.
- rst asserted at toggle 7 of a transfer: at the next edge cs=1, sclk=0, busy=0, and no done pulse.
  - A subsequent newd with din=12'h001 completes normally with dout=12'h001 (loopback).
- din, cpol and cpha changed mid-transfer (din 12'hFFF→12'h000, cpol 0→1): mosi and sclk continue with the latched values; sclk returns to the latched cpol=0 in TRAIL.
- Build without SPI_MASTER_MISO_EN, miso toggling: dout stays 0; cs, sclk and mosi waveforms match the first scenario cycle-for-cycle.
